rast_perf_counters: RTL and testbench
=====================================

Name: rast_perf_counters

Overview:
- Synthesizable performance-counter bank for the rasterizer pipeline. Counts enabled cycles plus NUM_EVT per-cycle event strobes, e.g. triangle accepted, sample tested, sample hit, halt asserted.
- Supports saturating or wrapping counters, sticky overflow flags, manual and periodic (windowed) snapshots, and an addressed registered readout of the snapshot bank.
- Sits beside the rasterizer core. Event inputs tap core valid/halt signals, and readout feeds debug/host logic.

Parameters:
- NUM_EVT, 4, number of event inputs (>=1)
- CNT_W, 32, width of every counter and snapshot register (>=2)
- WIN_W, 16, width of the snapshot-window period input
- SAT_MODE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
- AW, $clog2(NUM_EVT+1), readout address width (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en_RnnnnH  in  1  count enable
- clear_RnnnnH  in  1  synchronous clear of live counters, overflow flags, window counter
- snap_RnnnnH  in  1  manual snapshot request
- window_RnnnnU  in  WIN_W  auto-snapshot period in enabled cycles; 0 = disabled
- evt_RnnnnH  in  NUM_EVT  event strobes, one count per cycle per asserted bit
- rd_addr_RnnnnU  in  AW  snapshot select: 0 = cycle counter, i+1 = event i
- rd_data_RnnnnU  out  CNT_W  selected snapshot value
- snap_valid_RnnnnH  out  1  one-cycle pulse after a snapshot capture
- ovf_RnnnnH  out  NUM_EVT+1  sticky overflow flags, bit 0 = cycle counter

Behaviour:
- Reset (async assert, released synchronously by system):
  - all live counters, snapshots, window counter, rd_data, snap_valid and ovf = 0.
- Live counter index 0 increments on every edge with en=1.
- Live counter i+1 increments on an edge with en=1 and evt[i]=1.
- With en=0, no live counter or window counter changes. Manual snap and clear still act.
- Next value nxt[k] for an increment:
  - SAT_MODE=1: if live==all-ones, nxt=all-ones and ovf[k] is set.
  - SAT_MODE=0: if live==all-ones, nxt=0 and ovf[k] is set.
  - Otherwise nxt = live+1.
  - Without an increment, nxt = live.
- ovf bits stay set until clear or rst.
- Window counter (WIN_W bits), when en=1 and window!=0:
  - if wcnt >= window-1, then auto_snap=1 and wcnt <= 0;
  - else wcnt <= wcnt+1.
  - The >= compare makes a lowered window fire on the next enabled cycle.
  - window=0 forces wcnt <= 0 and no auto_snap.
- Capture occurs when snap=1 or auto_snap=1. On that edge, every snapshot k <= nxt[k], so the current cycle's events are included.
- snap_valid = 1 on the following cycle only.
- Back-to-back captures give snap_valid high on consecutive cycles.
- Clear:
  - live counters, wcnt and ovf <= 0 on that edge; snapshots are untouched.
  - Clear with capture on the same edge: the snapshot takes nxt (pre-clear value including this cycle), then live <= 0. This is snap-and-clear.
  - Clear with auto_snap: same rule.
- Readout:
  - rd_data registered, 1-cycle latency: rd_data <= snapshot[rd_addr].
  - rd_addr > NUM_EVT returns 0.
  - Reading the entry captured on the same edge returns the old snapshot; the new value appears one cycle later.
- Async rst mid-operation zeroes everything immediately, regardless of clock.
- No combinational path from inputs to outputs.

Test Plan:
1. Manual snapshot:
   - Stimulus: rst, then en=1 for 10 cycles, evt[0]=1 on 3 of them, evt[2]=1 on all 10; snap on cycle 10 (window=0).
   - Response: snap_valid pulses once; reads of addr 0/1/3/2 give 10/3/10/0; addr 5 gives 0.
2. Windowed snapshots:
   - Stimulus: window=4, en=1, evt[1]=1 always, 12 cycles.
   - Response: snap_valid pulses on cycles after edges 4, 8, 12; snapshot addr 2 reads 4, 8, 12 successively; wcnt returns to 0 each time.
3. Saturate vs wrap, CNT_W=4:
   - Stimulus: evt[0]=1 for 17 cycles, then snap.
   - Response: SAT_MODE=1 reads 15 with ovf[1]=1. SAT_MODE=0 reads 1 with ovf[1]=1. ovf[1] stays set until clear.
4. Snap-and-clear:
   - Stimulus: 5 enabled event cycles, then snap=1 and clear=1 on the same edge with evt[0]=1.
   - Response: snapshot addr 1 = 6; live counters = 0; a later snap after 2 idle enabled cycles with no events gives addr 0 = 2, addr 1 = 0.
5. Enable gating:
   - Stimulus: en=0 with evt all-ones for 8 cycles, window=2, then snap.
   - Response: all snapshots 0; no auto snap_valid; manual snap_valid pulses once.
6. Async reset mid-run:
   - Stimulus: assert rst between clock edges after counts reach 7.
   - Response: rd_data, ovf and snap_valid go to 0 immediately with no clock; after release, counting restarts from 0.

Source files
------------

// File: rtl/rast_perf_counters.sv
// rtl/rast_perf_counters.sv - rasterizer performance-counter bank with windowed snapshots
// Live counters feed a snapshot bank; host reads snapshots through a registered mux.
module rast_perf_counters #(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = 32,
    parameter int WIN_W    = 16,
    parameter int SAT_MODE = 1,
    parameter int AW       = $clog2(NUM_EVT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_RnnnnH,
    input  logic               clear_RnnnnH,
    input  logic               snap_RnnnnH,
    input  logic [WIN_W-1:0]   window_RnnnnU,
    input  logic [NUM_EVT-1:0] evt_RnnnnH,
    input  logic [AW-1:0]      rd_addr_RnnnnU,
    output logic [CNT_W-1:0]   rd_data_RnnnnU,
    output logic               snap_valid_RnnnnH,
    output logic [NUM_EVT:0]   ovf_RnnnnH
);

    localparam int NC = NUM_EVT + 1;
    localparam logic [CNT_W-1:0] ONES    = '1;
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    logic [CNT_W-1:0] live_q [NC];
    logic [CNT_W-1:0] live_d [NC];
    logic [CNT_W-1:0] snap_q [NC];
    logic [CNT_W-1:0] snap_d [NC];
    logic [CNT_W-1:0] nxt    [NC];
    logic [NC-1:0]    inc;
    logic [NC-1:0]    wrap_hit;
    logic [NC-1:0]    ovf_q, ovf_d;
    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             snap_valid_q;
    logic             auto_snap;
    logic             capture;

    // Index 0 is the enabled-cycle counter; index i+1 tracks evt[i].
    assign inc = {evt_RnnnnH & {NUM_EVT{en_RnnnnH}}, en_RnnnnH};

    // Lowering the window below the running count fires on the next enabled cycle.
    assign auto_snap = en_RnnnnH && (window_RnnnnU != '0) &&
                       (wcnt_q >= (window_RnnnnU - WIN_ONE));
    assign capture   = snap_RnnnnH || auto_snap;

    always_comb begin
        wrap_hit = '0;
        for (int k = 0; k < NC; k++) begin
            nxt[k] = live_q[k];
            if (inc[k]) begin
                if (live_q[k] == ONES) begin
                    wrap_hit[k] = 1'b1;
                    nxt[k]      = (SAT_MODE != 0) ? ONES : '0;
                end else begin
                    nxt[k] = live_q[k] + 1'b1;
                end
            end
        end
    end

    // Snapshots take nxt so a snap-and-clear edge still records this cycle's events.
    always_comb begin
        for (int k = 0; k < NC; k++) begin
            live_d[k] = clear_RnnnnH ? '0 : nxt[k];
            snap_d[k] = capture ? nxt[k] : snap_q[k];
        end
        ovf_d = clear_RnnnnH ? '0 : (ovf_q | wrap_hit);
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (clear_RnnnnH) begin
            wcnt_d = '0;
        end else if (en_RnnnnH) begin
            if ((window_RnnnnU == '0) || auto_snap) begin
                wcnt_d = '0;
            end else begin
                wcnt_d = wcnt_q + WIN_ONE;
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NC; k++) begin
            if (rd_addr_RnnnnU == AW'(k)) begin
                rd_data_d = snap_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NC; k++) begin
                live_q[k] <= '0;
                snap_q[k] <= '0;
            end
            ovf_q        <= '0;
            wcnt_q       <= '0;
            rd_data_q    <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                live_q[k] <= live_d[k];
                snap_q[k] <= snap_d[k];
            end
            ovf_q        <= ovf_d;
            wcnt_q       <= wcnt_d;
            rd_data_q    <= rd_data_d;
            snap_valid_q <= capture;
        end
    end

    assign rd_data_RnnnnU    = rd_data_q;
    assign snap_valid_RnnnnH = snap_valid_q;
    assign ovf_RnnnnH        = ovf_q;

endmodule

// File: tb/tb_rast_perf_counters.sv
// tb/tb_rast_perf_counters.sv - checks saturating and wrapping 4-bit counter banks against a model
// Directed scenarios with literal expectations, then randomized traffic.
module tb_rast_perf_counters;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, clear = 1'b0, snap = 1'b0;
    logic [15:0] window = '0;
    logic [3:0]  evt = '0;
    logic [2:0]  rd_addr = '0;

    logic [3:0]  rd_s, rd_w;
    logic        sv_s, sv_w;
    logic [4:0]  ovf_s, ovf_w;

    int total = 0;
    int bad   = 0;

    // Model state per bank: [0] saturating, [1] wrapping.
    int mlive [2][5];
    int msnap [2][5];
    int mwcnt [2];
    int mrd   [2];
    int movf  [2];
    int msv   [2];

    rast_perf_counters #(.NUM_EVT(4), .CNT_W(4), .WIN_W(16), .SAT_MODE(1)) u_sat (
        .clk(clk), .rst(rst), .en_RnnnnH(en), .clear_RnnnnH(clear), .snap_RnnnnH(snap),
        .window_RnnnnU(window), .evt_RnnnnH(evt), .rd_addr_RnnnnU(rd_addr),
        .rd_data_RnnnnU(rd_s), .snap_valid_RnnnnH(sv_s), .ovf_RnnnnH(ovf_s)
    );

    rast_perf_counters #(.NUM_EVT(4), .CNT_W(4), .WIN_W(16), .SAT_MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .en_RnnnnH(en), .clear_RnnnnH(clear), .snap_RnnnnH(snap),
        .window_RnnnnU(window), .evt_RnnnnH(evt), .rd_addr_RnnnnU(rd_addr),
        .rd_data_RnnnnU(rd_w), .snap_valid_RnnnnH(sv_w), .ovf_RnnnnH(ovf_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 5; k++) begin
                mlive[d][k] = 0;
                msnap[d][k] = 0;
            end
            mwcnt[d] = 0; mrd[d] = 0; movf[d] = 0; msv[d] = 0;
        end
    endtask

    task automatic model_step(input int d);
        int nx [5];
        int ovs;
        int cap;
        logic [4:0] hits;
        hits = en ? {evt, 1'b1} : 5'b0;
        cap  = (snap || (en && window != 0 && mwcnt[d] >= int'(window) - 1)) ? 1 : 0;
        mrd[d] = (rd_addr <= 3'd4) ? msnap[d][rd_addr] : 0;
        ovs = 0;
        for (int k = 0; k < 5; k++) begin
            nx[k] = mlive[d][k];
            if (hits[k]) begin
                if (mlive[d][k] + 1 > 15) ovs = ovs | (1 << k);
                nx[k] = (d == 0) ? ((mlive[d][k] + 1 > 15) ? 15 : mlive[d][k] + 1)
                                 : (mlive[d][k] + 1) % 16;
            end
            if (cap != 0) msnap[d][k] = nx[k];
            mlive[d][k] = clear ? 0 : nx[k];
        end
        msv[d] = cap;
        if (clear) begin
            movf[d]  = 0;
            mwcnt[d] = 0;
        end else begin
            movf[d] = movf[d] | ovs;
            if (en) mwcnt[d] = (cap != 0 && window != 0 && !snap) || window == 0 ? 0 :
                               (mwcnt[d] >= int'(window) - 1 ? 0 : mwcnt[d] + 1);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_zero();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        chk("rd_sat",   rd_s,  mrd[0]);
        chk("sv_sat",   sv_s,  msv[0]);
        chk("ovf_sat",  ovf_s, movf[0]);
        chk("rd_wrap",  rd_w,  mrd[1]);
        chk("sv_wrap",  sv_w,  msv[1]);
        chk("ovf_wrap", ovf_w, movf[1]);
    end

    task automatic step(input logic e, input logic [3:0] ev, input logic s, input logic c);
        en = e; evt = ev; snap = s; clear = c;
        @(posedge clk);
        #1;
        en = 1'b0; evt = '0; snap = 1'b0; clear = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_addr = a;
        step(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        model_zero();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rd", rd_s, 0);
        chk("rst_sv", sv_s, 0);
        chk("rst_ovf", ovf_s, 0);

        // Manual snapshot
        for (int i = 1; i <= 10; i++)
            step(1'b1, {1'b0, 1'b1, 1'b0, (i == 2 || i == 5 || i == 7)}, i == 10, 1'b0);
        chk("t1_sv", sv_s, 1);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("t1_sv_once", sv_s, 0);
        rd(0); chk("t1_a0", rd_s, 10);
        rd(1); chk("t1_a1", rd_s, 3);
        rd(3); chk("t1_a3", rd_s, 10);
        rd(2); chk("t1_a2", rd_s, 0);
        rd(5); chk("t1_a5", rd_s, 0);

        // Windowed snapshots
        step(1'b0, 4'h0, 1'b0, 1'b1);
        window = 16'd4;
        rd_addr = 3'd2;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 4'b0010, 1'b0, 1'b0);
            chk("t2_sv", sv_s, (i % 4 == 0) ? 1 : 0);
            if (i % 4 == 1 && i > 1) chk("t2_rd", rd_s, i - 1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("t2_rd12", rd_s, 12);
        window = '0;

        // Saturate vs wrap
        step(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        rd(1);
        chk("t3_sat", rd_s, 15);
        chk("t3_wrap", rd_w, 1);
        chk("t3_ovf_sat", ovf_s[1], 1);
        chk("t3_ovf_wrap", ovf_w[1], 1);
        repeat (3) step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("t3_ovf_sticky", ovf_s[1], 1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("t3_ovf_clr", ovf_s, 0);

        // Snap-and-clear
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 1'b1, 1'b1);
        rd(1); chk("t4_a1", rd_s, 6);
        step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        rd(0); chk("t4_a0", rd_s, 2);
        rd(1); chk("t4_a1_after", rd_w, 0);

        // Enable gating
        step(1'b0, 4'h0, 1'b0, 1'b1);
        window = 16'd2;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'hF, 1'b0, 1'b0);
            chk("t5_no_auto", sv_s, 0);
        end
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("t5_sv", sv_s, 1);
        for (int a = 0; a < 5; a++) begin
            rd(3'(a));
            chk("t5_zero", rd_s, 0);
        end
        window = '0;

        // Async reset mid-run
        for (int i = 0; i < 7; i++) step(1'b1, 4'hF, 1'b0, 1'b0);
        rd_addr = 3'd0;
        step(1'b0, 4'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("t6_pre_rd", rd_s, 7);
        chk("t6_pre_sv", sv_s, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_rd", rd_s, 0);
        chk("t6_rst_sv", sv_s, 0);
        chk("t6_rst_ovf", ovf_w, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        rd(0); chk("t6_restart", rd_s, 3);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) window = 16'($urandom_range(0, 6));
            rd_addr = 3'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 40) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
